// File: rtl/video_sync_gen.sv
// Programmable video timing generator: hs/vs/hbl/vbl/de plus position counters,
// with shadowed configuration applied at frame start and toggle-based frame realignment.
module video_sync_gen #(
  parameter int HW = 12,
  parameter int VW = 11
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic [HW-1:0] cfg_hact,
  input  logic [HW-1:0] cfg_hfp,
  input  logic [HW-1:0] cfg_hsw,
  input  logic [HW-1:0] cfg_hbp,
  input  logic [VW-1:0] cfg_vact,
  input  logic [VW-1:0] cfg_vfp,
  input  logic [VW-1:0] cfg_vsw,
  input  logic [VW-1:0] cfg_vbp,
  input  logic          cfg_hpol,
  input  logic          cfg_vpol,
  input  logic          cfg_load,
  output logic          cfg_pending,
  output logic          cfg_err,
  input  logic          sync_in,
  input  logic          lock_en,
  output logic          hs_out,
  output logic          vs_out,
  output logic          hbl_out,
  output logic          vbl_out,
  output logic          de_out,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          frame_start
);

  typedef struct packed {
    logic [HW-1:0] hact, hfp, hsw, hbp;
    logic [VW-1:0] vact, vfp, vsw, vbp;
    logic          hpol, vpol;
  } cfg_t;

  localparam cfg_t CFG_DEF = '{hact: HW'(640), hfp: HW'(16), hsw: HW'(96), hbp: HW'(48),
                               vact: VW'(480), vfp: VW'(10), vsw: VW'(2),  vbp: VW'(33),
                               hpol: 1'b1, vpol: 1'b1};

  function automatic logic [HW+1:0] htot_f(cfg_t c);
    return (HW+2)'(c.hact) + (HW+2)'(c.hfp) + (HW+2)'(c.hsw) + (HW+2)'(c.hbp);
  endfunction

  function automatic logic [VW+1:0] vtot_f(cfg_t c);
    return (VW+2)'(c.vact) + (VW+2)'(c.vfp) + (VW+2)'(c.vsw) + (VW+2)'(c.vbp);
  endfunction

  localparam logic [HW+1:0] HTOT_DEF = htot_f(CFG_DEF);
  localparam logic [VW+1:0] VTOT_DEF = vtot_f(CFG_DEF);
  localparam logic [HW-1:0] HCNT_RST = HW'(HTOT_DEF - 1'b1);
  localparam logic [VW-1:0] VCNT_RST = VW'(VTOT_DEF - 1'b1);

  cfg_t          act_q, act_d, pset_q, pset_d, cfg_in, eff;
  logic          pending_q, pending_d, err_q, err_d;
  logic          req_q, req_d, sync_q, sync_d;
  logic [HW-1:0] hcnt_q, hcnt_d, hcnt_n;
  logic [VW-1:0] vcnt_q, vcnt_d, vcnt_n;
  logic          hs_q, hs_d, vs_q, vs_d, hbl_q, hbl_d, vbl_q, vbl_d, de_q, de_d, fs_q, fs_d;
  logic [HW+1:0] htot_a, h_x, hs_beg, hs_end;
  logic [VW+1:0] vtot_a, v_x, vs_beg, vs_end;
  logic          line_end, fs_evt, apply, pset_ok;

  always_comb begin
    cfg_in = '{hact: cfg_hact, hfp: cfg_hfp, hsw: cfg_hsw, hbp: cfg_hbp,
               vact: cfg_vact, vfp: cfg_vfp, vsw: cfg_vsw, vbp: cfg_vbp,
               hpol: cfg_hpol, vpol: cfg_vpol};
    pset_ok = (|pset_q.hact) && (|pset_q.hfp) && (|pset_q.hsw) && (|pset_q.hbp) &&
              (|pset_q.vact) && (|pset_q.vfp) && (|pset_q.vsw) && (|pset_q.vbp) &&
              (htot_f(pset_q) <= (HW+2)'(2**HW)) && (vtot_f(pset_q) <= (VW+2)'(2**VW));

    htot_a   = htot_f(act_q);
    vtot_a   = vtot_f(act_q);
    line_end = ({2'b00, hcnt_q} == htot_a - 1'b1);
    fs_evt   = line_end & (req_q | ({2'b00, vcnt_q} == vtot_a - 1'b1));
    // A load landing on the apply clock replaces the pending set instead of applying it.
    apply    = ce_pix & fs_evt & pending_q & ~cfg_load;

    hcnt_n = line_end ? '0 : hcnt_q + 1'b1;
    vcnt_n = !line_end ? vcnt_q : (fs_evt ? '0 : vcnt_q + 1'b1);

    // The first line of a new frame is decoded with the set that takes effect there.
    eff    = (apply & pset_ok) ? pset_q : act_q;
    h_x    = {2'b00, hcnt_n};
    v_x    = {2'b00, vcnt_n};
    hs_beg = (HW+2)'(eff.hact) + (HW+2)'(eff.hfp);
    hs_end = hs_beg + (HW+2)'(eff.hsw);
    vs_beg = (VW+2)'(eff.vact) + (VW+2)'(eff.vfp);
    vs_end = vs_beg + (VW+2)'(eff.vsw);

    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    hbl_d  = hbl_q;
    vbl_d  = vbl_q;
    de_d   = de_q;
    fs_d   = 1'b0;
    if (ce_pix) begin
      hcnt_d = hcnt_n;
      vcnt_d = vcnt_n;
      hbl_d  = (h_x >= (HW+2)'(eff.hact));
      vbl_d  = (v_x >= (VW+2)'(eff.vact));
      de_d   = ~hbl_d & ~vbl_d;
      hs_d   = ((h_x >= hs_beg) && (h_x < hs_end)) ^ eff.hpol;
      vs_d   = ((v_x >= vs_beg) && (v_x < vs_end)) ^ eff.vpol;
      fs_d   = fs_evt;
    end

    req_d  = (req_q & ~(ce_pix & line_end)) | (lock_en & (sync_in ^ sync_q));
    sync_d = sync_in;

    act_d     = act_q;
    pset_d    = pset_q;
    pending_d = pending_q;
    err_d     = err_q;
    if (cfg_load) begin
      pset_d    = cfg_in;
      pending_d = 1'b1;
      err_d     = 1'b0;
    end else if (apply) begin
      pending_d = 1'b0;
      if (pset_ok) act_d = pset_q;
      else         err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_q     <= CFG_DEF;
      pset_q    <= CFG_DEF;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      sync_q    <= sync_in;
      hcnt_q    <= HCNT_RST;
      vcnt_q    <= VCNT_RST;
      hs_q      <= CFG_DEF.hpol;
      vs_q      <= CFG_DEF.vpol;
      hbl_q     <= 1'b1;
      vbl_q     <= 1'b1;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      act_q     <= act_d;
      pset_q    <= pset_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      req_q     <= req_d;
      sync_q    <= sync_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hbl_q     <= hbl_d;
      vbl_q     <= vbl_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
    end
  end

  assign cfg_pending = pending_q;
  assign cfg_err     = err_q;
  assign hs_out      = hs_q;
  assign vs_out      = vs_q;
  assign hbl_out     = hbl_q;
  assign vbl_out     = vbl_q;
  assign de_out      = de_q;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_video_sync_gen.sv
module tb_video_sync_gen;
  localparam int HW = 12;
  localparam int VW = 11;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce_pix = 1'b1;
  logic [HW-1:0] cfg_hact = '0, cfg_hfp = '0, cfg_hsw = '0, cfg_hbp = '0;
  logic [VW-1:0] cfg_vact = '0, cfg_vfp = '0, cfg_vsw = '0, cfg_vbp = '0;
  logic          cfg_hpol = 1'b1, cfg_vpol = 1'b1, cfg_load = 1'b0;
  logic          sync_in = 1'b0, lock_en = 1'b1;
  logic          cfg_pending, cfg_err, hs_out, vs_out, hbl_out, vbl_out, de_out, frame_start;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  video_sync_gen #(.HW(HW), .VW(VW)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
    .cfg_hact(cfg_hact), .cfg_hfp(cfg_hfp), .cfg_hsw(cfg_hsw), .cfg_hbp(cfg_hbp),
    .cfg_vact(cfg_vact), .cfg_vfp(cfg_vfp), .cfg_vsw(cfg_vsw), .cfg_vbp(cfg_vbp),
    .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .sync_in(sync_in), .lock_en(lock_en),
    .hs_out(hs_out), .vs_out(vs_out), .hbl_out(hbl_out), .vbl_out(vbl_out), .de_out(de_out),
    .hcnt(hcnt), .vcnt(vcnt), .frame_start(frame_start));

  always #5 clk = ~clk;

  typedef struct {
    int hact, hfp, hsw, hbp, vact, vfp, vsw, vbp;
    bit hpol, vpol;
  } mcfg_t;

  typedef struct {
    int h, v;
    bit hs, vs, hbl, vbl, de, fs, pend, err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0, cyc = 0;

  function automatic mcfg_t def_cfg();
    mcfg_t c;
    c.hact = 640; c.hfp = 16; c.hsw = 96; c.hbp = 48;
    c.vact = 480; c.vfp = 10; c.vsw = 2;  c.vbp = 33;
    c.hpol = 1;   c.vpol = 1;
    return c;
  endfunction

  function automatic int htot(mcfg_t c); return c.hact + c.hfp + c.hsw + c.hbp; endfunction
  function automatic int vtot(mcfg_t c); return c.vact + c.vfp + c.vsw + c.vbp; endfunction

  function automatic bit cfg_valid(mcfg_t c);
    return c.hact > 0 && c.hfp > 0 && c.hsw > 0 && c.hbp > 0 &&
           c.vact > 0 && c.vfp > 0 && c.vsw > 0 && c.vbp > 0 &&
           htot(c) <= 4096 && vtot(c) <= 2048;
  endfunction

  mcfg_t m_act, m_pset;
  int    m_h, m_v;
  bit    m_pend, m_err, m_req, m_sync, m_chg;
  bit    o_hs, o_vs, o_hbl, o_vbl, o_de, o_fs;

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!reset_n) begin
      m_act = def_cfg();
      m_h = htot(m_act) - 1; m_v = vtot(m_act) - 1;
      m_pend = 0; m_err = 0; m_req = 0; m_sync = sync_in;
      o_hbl = 1; o_vbl = 1; o_de = 0; o_hs = m_act.hpol; o_vs = m_act.vpol; o_fs = 0;
    end else begin
      m_chg  = (sync_in != m_sync);
      m_sync = sync_in;
      o_fs   = 0;
      if (ce_pix) begin
        if (m_h == htot(m_act) - 1) begin
          m_h = 0;
          if (m_req || m_v == vtot(m_act) - 1) begin
            m_v = 0; o_fs = 1; m_req = 0;
            if (m_pend && !cfg_load) begin
              m_pend = 0;
              if (cfg_valid(m_pset)) m_act = m_pset;
              else m_err = 1;
            end
          end else m_v++;
        end else m_h++;
        o_hbl = m_h >= m_act.hact;
        o_vbl = m_v >= m_act.vact;
        o_de  = !o_hbl && !o_vbl;
        o_hs  = (m_h >= m_act.hact + m_act.hfp && m_h < m_act.hact + m_act.hfp + m_act.hsw) ^ m_act.hpol;
        o_vs  = (m_v >= m_act.vact + m_act.vfp && m_v < m_act.vact + m_act.vfp + m_act.vsw) ^ m_act.vpol;
      end
      if (cfg_load) begin
        m_pset.hact = cfg_hact; m_pset.hfp = cfg_hfp; m_pset.hsw = cfg_hsw; m_pset.hbp = cfg_hbp;
        m_pset.vact = cfg_vact; m_pset.vfp = cfg_vfp; m_pset.vsw = cfg_vsw; m_pset.vbp = cfg_vbp;
        m_pset.hpol = cfg_hpol; m_pset.vpol = cfg_vpol;
        m_pend = 1; m_err = 0;
      end
      if (lock_en && m_chg) m_req = 1;
    end
    e.h = m_h; e.v = m_v; e.hs = o_hs; e.vs = o_vs; e.hbl = o_hbl; e.vbl = o_vbl;
    e.de = o_de; e.fs = o_fs; e.pend = m_pend; e.err = m_err;
    exp_q.push_back(e);
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (int'(hcnt) !== e.h || int'(vcnt) !== e.v || hs_out !== e.hs || vs_out !== e.vs ||
            hbl_out !== e.hbl || vbl_out !== e.vbl || de_out !== e.de ||
            frame_start !== e.fs || cfg_pending !== e.pend || cfg_err !== e.err) begin
          n_err++;
          $display("FAIL timing cyc=%0d got h=%0d v=%0d hs%b vs%b hb%b vb%b de%b fs%b p%b e%b req h=%0d v=%0d hs%b vs%b hb%b vb%b de%b fs%b p%b e%b",
                   cyc, hcnt, vcnt, hs_out, vs_out, hbl_out, vbl_out, de_out, frame_start, cfg_pending, cfg_err,
                   e.h, e.v, e.hs, e.vs, e.hbl, e.vbl, e.de, e.fs, e.pend, e.err);
        end
      end
    end
  end

  int ce_den = 1, tog_rate = 0, load_rate = 0;

  task automatic rand_cfg();
    int r;
    r = $urandom_range(19);
    cfg_hact = HW'($urandom_range(10, 1)); cfg_hfp = HW'($urandom_range(4, 1));
    cfg_hsw  = HW'($urandom_range(4, 1));  cfg_hbp = HW'($urandom_range(4, 1));
    cfg_vact = VW'($urandom_range(5, 1));  cfg_vfp = VW'($urandom_range(3, 1));
    cfg_vsw  = VW'($urandom_range(3, 1));  cfg_vbp = VW'($urandom_range(3, 1));
    cfg_hpol = 1'($urandom_range(1));      cfg_vpol = 1'($urandom_range(1));
    if (r == 0) cfg_hbp = '0;
    else if (r == 1) cfg_vsw = '0;
    else if (r == 2) begin cfg_hact = '1; cfg_hfp = '1; end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cfg_load = 1'b0;
      ce_pix = (ce_den <= 1) ? 1'b1 : ($urandom_range(ce_den - 1) == 0);
      if (tog_rate > 0 && $urandom_range(tog_rate - 1) == 0) sync_in = ~sync_in;
      if (load_rate > 0 && $urandom_range(load_rate - 1) == 0) begin rand_cfg(); cfg_load = 1'b1; end
    end
  endtask

  task automatic ld(int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb);
    @(negedge clk);
    cfg_hact = HW'(ha); cfg_hfp = HW'(hf); cfg_hsw = HW'(hs); cfg_hbp = HW'(hb);
    cfg_vact = VW'(va); cfg_vfp = VW'(vf); cfg_vsw = VW'(vs); cfg_vbp = VW'(vb);
    cfg_hpol = 1'b1; cfg_vpol = 1'b1; cfg_load = 1'b1; ce_pix = 1'b1;
  endtask

  task automatic tog();
    @(negedge clk);
    cfg_load = 1'b0;
    sync_in = ~sync_in;
  endtask

  task automatic rst_pulse(int n);
    @(negedge clk);
    cfg_load = 1'b0;
    reset_n = 1'b0;
    run(n - 1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bit fs_seen;
    run(3);
    if (hcnt !== HW'(799) || vcnt !== VW'(524) || hbl_out !== 1'b1 || vbl_out !== 1'b1 ||
        de_out !== 1'b0 || hs_out !== 1'b1 || vs_out !== 1'b1 || frame_start !== 1'b0 ||
        cfg_pending !== 1'b0 || cfg_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset state h=%0d v=%0d hb%b vb%b de%b hs%b vs%b fs%b p%b e%b",
               hcnt, vcnt, hbl_out, vbl_out, de_out, hs_out, vs_out, frame_start, cfg_pending, cfg_err);
    end
    reset_n = 1'b1;
    fs_seen = 1'b0;
    for (int i = 0; i < 16 && !fs_seen; i++) begin
      @(negedge clk);
      cfg_load = 1'b0;
      ce_pix = 1'b1;
      if (frame_start === 1'b1) begin
        fs_seen = 1'b1;
        if (hcnt !== '0 || vcnt !== '0 || de_out !== 1'b1) begin
          n_err++;
          $display("FAIL first frame h=%0d v=%0d de%b", hcnt, vcnt, de_out);
        end
      end
    end
    if (!fs_seen) begin
      n_err++;
      $display("FAIL timeout: no frame_start within 16 clks after reset");
    end
    run(1700);
    ce_den = 3; run(2600); ce_den = 1;
    ld(720, 12, 64, 68, 480, 10, 2, 33);
    run(500); tog(); run(2000);
    ld(20, 3, 0, 5, 6, 2, 2, 3);
    run(20); tog(); run(900);
    ld(20, 3, 4, 5, 6, 2, 2, 3);
    run(20); tog(); run(900);
    ld(4094, 1, 1, 1, 3, 1, 1, 1);
    run(20); tog(); run(700);
    ld(4093, 1, 1, 1, 3, 1, 1, 1);
    run(20); tog(); run(9000);
    ld(12, 2, 2, 2, 4, 1, 1, 1);
    run(10); rst_pulse(1); run(60);
    ld(20, 3, 4, 5, 6, 2, 2, 3);
    run(5); tog(); run(900);
    lock_en = 1'b0; tog_rate = 50; run(600); tog_rate = 0; lock_en = 1'b1;
    for (int s = 0; s < 40; s++) begin
      ce_den    = $urandom_range(3, 1);
      tog_rate  = ($urandom_range(1) == 1) ? 200 : 0;
      load_rate = 300;
      lock_en   = ($urandom_range(3) != 0);
      if ($urandom_range(9) == 0) begin
        rst_pulse($urandom_range(3, 1));
        rand_cfg(); cfg_load = 1'b1;
        tog();
      end
      run(1000);
    end
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end
endmodule
